// File: rtl/stopwatch_ctrl_if.sv
// Raw push-button inputs and counter/display control outputs of the stopwatch sequencer.
// The host side (master) drives the buttons; the sequencer (slave) drives the controls.
interface stopwatch_ctrl_if;
    logic       start;
    logic       stop;
    logic       lap;
    logic       clear;
    logic       run;
    logic       tick;
    logic       clr;
    logic       cap;
    logic       freeze;
    logic [1:0] state;

    modport master (
        output start, stop, lap, clear,
        input  run, tick, clr, cap, freeze, state
    );

    modport slave (
        input  start, stop, lap, clear,
        output run, tick, clr, cap, freeze, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions four raw buttons into one-cycle events and
// runs the IDLE/RUN/PAUSE/LAP FSM that generates tick, clr, cap and freeze.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned DB_LEN   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    stopwatch_ctrl_if.slave sw
);

    localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
    localparam int unsigned      DB_W     = $clog2(DB_LEN + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_LEN - 1);

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_CLEAR = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_STOP,
        EV_START,
        EV_LAP,
        EV_CLEAR
    } evt_e;

    logic [3:0]      raw;
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [3:0]      db_q;
    logic [3:0]      db_d;
    logic [3:0]      db_dly_q;
    logic [3:0]      evt_q;
    logic [3:0]      evt_d;
    logic [DB_W-1:0] cnt_q [4];
    logic [DB_W-1:0] cnt_d [4];

    evt_e             top_evt;
    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic             clr_q;
    logic             cap_q;

    assign raw = {sw.clear, sw.lap, sw.stop, sw.start};

    // NOTE: every variable gets a default at the top of an always_comb, so no path can leave one unassigned and infer a latch.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
        evt_d = db_q & ~db_dly_q;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            evt_q    <= '0;
            // NOTE: the debounce counters are a small register array, not a RAM, so they are reset like any other flop.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            evt_q    <= evt_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Only the single highest-priority event is offered to the FSM; if illegal it is simply dropped.
    always_comb begin
        top_evt = EV_NONE;
        if (evt_q[BTN_STOP])       top_evt = EV_STOP;
        else if (evt_q[BTN_START]) top_evt = EV_START;
        else if (evt_q[BTN_LAP])   top_evt = EV_LAP;
        else if (evt_q[BTN_CLEAR]) top_evt = EV_CLEAR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            clr_q  <= 1'b0;
            cap_q  <= 1'b0;

            if (state_q == S_RUN || state_q == S_LAP) begin
                if (div_q == DIV_LAST) begin
                    div_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    if (top_evt == EV_START) begin
                        state_q <= S_RUN;
                    end else if (top_evt == EV_CLEAR) begin
                        clr_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (top_evt == EV_STOP) begin
                        state_q <= S_PAUSE;
                    end else if (top_evt == EV_LAP) begin
                        state_q <= S_LAP;
                        cap_q   <= 1'b1;
                    end
                end
                S_LAP: begin
                    if (top_evt == EV_STOP) begin
                        state_q <= S_PAUSE;
                    end else if (top_evt == EV_LAP) begin
                        cap_q <= 1'b1;
                    end else if (top_evt == EV_CLEAR) begin
                        state_q <= S_RUN;
                    end
                end
                S_PAUSE: begin
                    // Divider holds here so resuming keeps the tick phase.
                    if (top_evt == EV_START) begin
                        state_q <= S_RUN;
                    end else if (top_evt == EV_CLEAR) begin
                        state_q <= S_IDLE;
                        clr_q   <= 1'b1;
                        div_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign sw.run    = (state_q == S_RUN) || (state_q == S_LAP);
    assign sw.freeze = (state_q == S_LAP);
    assign sw.state  = state_q;
    assign sw.tick   = tick_q;
    assign sw.clr    = clr_q;
    assign sw.cap    = cap_q;

endmodule
